io_cmd_master: RTL and testbench

IO_CMD_MASTER -- requirements
Module: io_cmd_master

---
 rtl/io_cmd_master_if.sv | 36 +++
 rtl/io_cmd_master.sv | 175 +++++++++++++++++
 tb/tb_io_cmd_master.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/io_cmd_master_if.sv
`default_nettype none
// ============================================================================
// Module      : io_cmd_master_if
// Description : Host request/response, IO responder and UART receive bundle.
// Revision    : 1.0
// ============================================================================
interface io_cmd_master_if;
  logic        req_valid;
  logic        req_ready;
  logic [7:0]  req_op;
  logic [15:0] req_arg;
  logic        resp_valid;
  logic [23:0] resp_data;
  logic        resp_timeout;
  logic        cmd_start;
  logic [23:0] cmd_word;
  logic        cmd_rdy;
  logic [23:0] cmd_data;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_pop;
  logic        rx_overflow;

  modport master (
    input  req_valid, req_op, req_arg, cmd_rdy, cmd_data, rx_pop,
    output req_ready, resp_valid, resp_data, resp_timeout,
           cmd_start, cmd_word, rx_valid, rx_data, rx_overflow
  );

  modport slave (
    output req_valid, req_op, req_arg, cmd_rdy, cmd_data, rx_pop,
    input  req_ready, resp_valid, resp_data, resp_timeout,
           cmd_start, cmd_word, rx_valid, rx_data, rx_overflow
  );
endinterface
`default_nettype wire

// File: rtl/io_cmd_master.sv
`default_nettype none
// ============================================================================
// Module      : io_cmd_master
// Description : Issues host commands to an IO responder, collects read data
//               with timeout, and buffers unsolicited UART receive bytes.
//               IO_CMD_MASTER_RXFIFO_EN selects a 4-deep receive FIFO instead
//               of a single receive register.
// Revision    : 1.0
// ============================================================================
module io_cmd_master #(
  parameter int         TIMEOUT = 16,
  parameter logic [7:0] RD_OP   = 8'h08
) (
  input wire logic          clk,
  input wire logic          rst,
  io_cmd_master_if.master   bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam logic [7:0] c_TIMEOUT = TIMEOUT[7:0];

  logic [1:0]  r_state;
  logic [1:0]  w_next;
  logic [7:0]  r_op;
  logic [15:0] r_arg;
  logic [7:0]  r_cnt;
  logic [23:0] r_resp_data;
  logic        r_timeout;
  logic        r_rx_overflow;

  logic        w_accept;
  logic        w_is_read;
  logic        w_rx_push;
  logic        w_rx_pop;
  logic        w_rx_wr;
  logic        w_rx_full;
  logic        w_rx_valid;
  logic [7:0]  w_rx_head;

  assign w_accept  = bus.req_valid && (r_state == S_IDLE);
  assign w_is_read = (r_op == RD_OP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_ISSUE;
      S_ISSUE: w_next = (!w_is_read || bus.cmd_rdy) ? S_RESP : S_WAIT;
      S_WAIT:  if (bus.cmd_rdy || (r_cnt == c_TIMEOUT)) w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready    = (r_state == S_IDLE);
    bus.cmd_start    = (r_state == S_ISSUE);
    bus.cmd_word     = (r_state == S_ISSUE) ? {r_op, r_arg} : 24'h0;
    bus.resp_valid   = (r_state == S_RESP);
    bus.resp_data    = (r_state == S_RESP) ? r_resp_data : 24'h0;
    bus.resp_timeout = (r_state == S_RESP) && r_timeout;
  end

  // Command datapath: captured operands, WAIT counter and response payload.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op        <= 8'h0;
      r_arg       <= 16'h0;
      r_cnt       <= 8'h0;
      r_resp_data <= 24'h0;
      r_timeout   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op        <= bus.req_op;
        r_arg       <= bus.req_arg;
        r_resp_data <= 24'h0;
        r_timeout   <= 1'b0;
      end
      case (r_state)
        S_ISSUE: begin
          r_cnt <= 8'h0;
          if (w_is_read && bus.cmd_rdy) r_resp_data <= bus.cmd_data;
        end
        S_WAIT: begin
          if (bus.cmd_rdy)              r_resp_data <= bus.cmd_data;
          else if (r_cnt == c_TIMEOUT)  r_timeout   <= 1'b1;
          else                          r_cnt       <= r_cnt + 8'd1;
        end
        default: ;
      endcase
    end
  end

  // Responder strobes outside a pending read are UART receive bytes.
  assign w_rx_push = bus.cmd_rdy &&
                     ((r_state == S_IDLE) || (r_state == S_RESP) ||
                      ((r_state == S_ISSUE) && !w_is_read));
  assign w_rx_pop  = bus.rx_pop && w_rx_valid;
  assign w_rx_wr   = w_rx_push && (!w_rx_full || w_rx_pop);

`ifdef IO_CMD_MASTER_RXFIFO_EN
  logic [7:0] r_mem [4];
  logic [1:0] r_wr_ptr;
  logic [1:0] r_rd_ptr;
  logic [2:0] r_count;

  assign w_rx_full  = (r_count == 3'd4);
  assign w_rx_valid = (r_count != 3'd0);
  assign w_rx_head  = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_rx_wr) r_mem[r_wr_ptr] <= bus.cmd_data[7:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= 2'd0;
      r_rd_ptr <= 2'd0;
      r_count  <= 3'd0;
    end else begin
      if (w_rx_wr)  r_wr_ptr <= r_wr_ptr + 2'd1;
      if (w_rx_pop) r_rd_ptr <= r_rd_ptr + 2'd1;
      case ({w_rx_wr, w_rx_pop})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
    end
  end
`else
  logic       r_rx_valid;
  logic [7:0] r_rx_data;

  assign w_rx_full  = r_rx_valid;
  assign w_rx_valid = r_rx_valid;
  assign w_rx_head  = r_rx_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_valid <= 1'b0;
      r_rx_data  <= 8'h0;
    end else if (w_rx_wr) begin
      r_rx_valid <= 1'b1;
      r_rx_data  <= bus.cmd_data[7:0];
    end else if (w_rx_pop) begin
      r_rx_valid <= 1'b0;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_overflow <= 1'b0;
    end else if (w_rx_push && !w_rx_wr) begin
      r_rx_overflow <= 1'b1;
    end
  end

  assign bus.rx_valid    = w_rx_valid;
  assign bus.rx_data     = w_rx_valid ? w_rx_head : 8'h0;
  assign bus.rx_overflow = r_rx_overflow;

endmodule
`default_nettype wire

// File: tb/tb_io_cmd_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_io_cmd_master
// Description : Scoreboard bench for io_cmd_master (both receive-store builds).
// Revision    : 1.0
// ============================================================================
module tb_io_cmd_master;
  localparam int TMO = 16;
`ifdef IO_CMD_MASTER_RXFIFO_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1;
`endif

  typedef struct {
    logic [23:0] data;
    logic        tmo;
    int          cyc;
  } resp_t;

  typedef struct {
    logic [23:0] word;
    int          cyc;
  } cmd_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  io_cmd_master_if bus();

  io_cmd_master #(.TIMEOUT(TMO), .RD_OP(8'h08)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  resp_t      sb[$];
  cmd_t       cq[$];
  logic [7:0] rxq[$];
  logic       ovf_exp = 1'b0;
  logic       prev_resp = 1'b0;
  int         n_checks = 0;
  int         n_errors = 0;
  int         ecount = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  always @(posedge clk) ecount <= ecount + 1;

  always @(negedge clk) begin
    resp_t e;
    cmd_t  c;
    if (bus.resp_valid) begin
      check_val("ready_in_resp", {31'h0, bus.req_ready}, 32'h0);
      if (sb.size() == 0) begin
        check_val("resp_unexpected", 32'h1, 32'h0);
      end else begin
        e = sb.pop_front();
        check_val("resp_data", {8'h0, bus.resp_data}, {8'h0, e.data});
        check_val("resp_timeout", {31'h0, bus.resp_timeout}, {31'h0, e.tmo});
        check_val("resp_cycle", ecount, e.cyc);
      end
    end else begin
      check_val("timeout_idle", {31'h0, bus.resp_timeout}, 32'h0);
    end
    if (bus.cmd_start) begin
      if (cq.size() == 0) begin
        check_val("cmd_unexpected", 32'h1, 32'h0);
      end else begin
        c = cq.pop_front();
        check_val("cmd_word", {8'h0, bus.cmd_word}, {8'h0, c.word});
        check_val("cmd_cycle", ecount, c.cyc);
      end
    end else begin
      check_val("cmd_word_idle", {8'h0, bus.cmd_word}, 32'h0);
    end
    if (prev_resp) check_val("ready_after_resp", {31'h0, bus.req_ready}, 32'h1);
    prev_resp <= bus.resp_valid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [7:0] op, input logic [15:0] arg, output int base);
    int b;
    b = 0;
    while (!bus.req_ready && b < 50) begin
      tick();
      b++;
    end
    bus.req_op    = op;
    bus.req_arg   = arg;
    bus.req_valid = 1'b1;
    tick();
    base          = ecount;
    bus.req_valid = 1'b0;
    cq.push_back('{word: {op, arg}, cyc: base});
  endtask

  task automatic drain();
    int b;
    b = 0;
    while ((sb.size() != 0 || cq.size() != 0) && b < 60) begin
      tick();
      b++;
    end
    if (b >= 60) begin
      check_val("resp_missing", sb.size(), 0);
      sb.delete();
      cq.delete();
    end
    tick();
  endtask

  task automatic model_push(input logic [7:0] b);
    if (rxq.size() < DEPTH) rxq.push_back(b);
    else ovf_exp = 1'b1;
  endtask

  task automatic rx_push(input logic [7:0] b, input logic pop);
    if (pop && rxq.size() > 0) begin
      check_val("rx_head_pp", {24'h0, bus.rx_data}, {24'h0, rxq[0]});
      void'(rxq.pop_front());
    end
    model_push(b);
    bus.cmd_rdy  = 1'b1;
    bus.cmd_data = {16'hC0DE, b};
    bus.rx_pop   = pop;
    tick();
    bus.cmd_rdy  = 1'b0;
    bus.rx_pop   = 1'b0;
  endtask

  task automatic rx_drain_all();
    while (rxq.size() > 0) begin
      check_val("rx_valid", {31'h0, bus.rx_valid}, 32'h1);
      check_val("rx_data", {24'h0, bus.rx_data}, {24'h0, rxq[0]});
      void'(rxq.pop_front());
      bus.rx_pop = 1'b1;
      tick();
      bus.rx_pop = 1'b0;
    end
    check_val("rx_empty", {31'h0, bus.rx_valid}, 32'h0);
    check_val("rx_overflow", {31'h0, bus.rx_overflow}, {31'h0, ovf_exp});
  endtask

  task automatic do_write(input logic [7:0] op, input logic [15:0] arg,
                          input logic with_rx, input logic [7:0] b);
    int base;
    issue(op, arg, base);
    sb.push_back('{data: 24'h0, tmo: 1'b0, cyc: base + 1});
    if (with_rx) begin
      model_push(b);
      bus.cmd_rdy  = 1'b1;
      bus.cmd_data = {16'h0, b};
      tick();
      bus.cmd_rdy  = 1'b0;
    end
    drain();
  endtask

  // n = -1: answered in ISSUE; n >= 0: answered in WAIT cycle n; n = -2: never answered
  task automatic do_read(input logic [15:0] arg, input int n, input logic [23:0] d);
    int base;
    issue(8'h08, arg, base);
    if (n == -2) begin
      sb.push_back('{data: 24'h0, tmo: 1'b1, cyc: base + 2 + TMO});
    end else begin
      sb.push_back('{data: d, tmo: 1'b0, cyc: (n < 0) ? base + 1 : base + 2 + n});
      if (n >= 0) repeat (n + 1) tick();
      bus.cmd_rdy  = 1'b1;
      bus.cmd_data = d;
      tick();
      bus.cmd_rdy  = 1'b0;
    end
    drain();
    check_val("rd_no_rx_push", {31'h0, bus.rx_valid}, {31'h0, rxq.size() != 0});
  endtask

  initial begin
    int base;
    bus.req_valid = 1'b0;
    bus.req_op    = 8'h0;
    bus.req_arg   = 16'h0;
    bus.cmd_rdy   = 1'b0;
    bus.cmd_data  = 24'h0;
    bus.rx_pop    = 1'b0;
    #12;
    check_val("rst_req_ready", {31'h0, bus.req_ready}, 32'h1);
    check_val("rst_resp_valid", {31'h0, bus.resp_valid}, 32'h0);
    check_val("rst_resp_data", {8'h0, bus.resp_data}, 32'h0);
    check_val("rst_cmd_start", {31'h0, bus.cmd_start}, 32'h0);
    check_val("rst_cmd_word", {8'h0, bus.cmd_word}, 32'h0);
    check_val("rst_rx_valid", {31'h0, bus.rx_valid}, 32'h0);
    check_val("rst_rx_data", {24'h0, bus.rx_data}, 32'h0);
    check_val("rst_rx_overflow", {31'h0, bus.rx_overflow}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    do_write(8'h05, 16'h0002, 1'b0, 8'h00);
    do_write(8'hFF, 16'hBEEF, 1'b1, 8'h5A);
    rx_drain_all();
    do_read(16'h0001, -1, 24'h123456);
    do_read(16'h0002, 2, 24'h00A5C3);
    do_read(16'h0003, 0, 24'hABCDEF);
    do_read(16'h0004, -2, 24'h0);
    do_read(16'h0005, TMO, 24'h7E7E7E);
    do_read(16'h0006, TMO - 1, 24'h010203);

    bus.rx_pop = 1'b1;
    tick();
    bus.rx_pop = 1'b0;
    check_val("pop_empty_ignored", {31'h0, bus.rx_valid}, 32'h0);
    for (int i = 0; i < DEPTH; i++) rx_push(8'h10 + 8'(i), 1'b0);
    rx_push(8'h77, 1'b1);
    check_val("full_push_pop_no_ovf", {31'h0, bus.rx_overflow}, 32'h0);
    rx_drain_all();

    for (int i = 0; i < 5; i++) rx_push(8'h41 + 8'(i), 1'b0);
    check_val("rx_ovf_set", {31'h0, bus.rx_overflow}, 32'h1);
    rx_drain_all();

    rx_push(8'h99, 1'b0);
    issue(8'h08, 16'h00AA, base);
    repeat (3) tick();
    rst = 1'b1;
    #1;
    check_val("midwait_rst_ready", {31'h0, bus.req_ready}, 32'h1);
    check_val("midwait_rst_rx_valid", {31'h0, bus.rx_valid}, 32'h0);
    check_val("midwait_rst_ovf", {31'h0, bus.rx_overflow}, 32'h0);
    check_val("midwait_rst_resp", {31'h0, bus.resp_valid}, 32'h0);
    rxq.delete();
    ovf_exp = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    rst = 1'b0;
    repeat (TMO + 8) tick();

    do_write(8'h21, 16'h4321, 1'b0, 8'h00);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire
